mult_sequencer: RTL



---
 rtl/mult_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mult_sequencer.sv
// Strobe sequencer for the shift-add Multiplier datapath: host valid/ready in, Start..Reset_Sync out.
// Optional WAIT_READY timeout is enabled by defining MULT_SEQ_TIMEOUT_EN.
module mult_sequencer #(
  parameter int WORD_LENGTH    = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     op_valid,
  input  logic [WORD_LENGTH-1:0]   op_a,
  input  logic [WORD_LENGTH-1:0]   op_b,
  output logic                     op_ready,
  output logic [2*WORD_LENGTH-1:0] result,
  output logic                     result_cout,
  output logic                     result_valid,
  output logic                     timeout_err,
  output logic [WORD_LENGTH-1:0]   data_in_a,
  output logic [WORD_LENGTH-1:0]   data_in_b,
  output logic                     Start,
  output logic                     FinishLoad,
  output logic                     FinishShift,
  output logic                     Finish,
  output logic                     Reset_Sync,
  input  logic [2*WORD_LENGTH-1:0] data_out,
  input  logic                     cout,
  input  logic                     ready
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] START      = 3'd1;
  localparam logic [2:0] LOAD       = 3'd2;
  localparam logic [2:0] SHIFT      = 3'd3;
  localparam logic [2:0] FSHIFT     = 3'd4;
  localparam logic [2:0] WAIT_READY = 3'd5;
  localparam logic [2:0] FINISH     = 3'd6;
  localparam logic [2:0] CLEAR      = 3'd7;

  localparam int SW = $clog2(WORD_LENGTH) + 1;
  localparam logic [SW-1:0] SHIFT_LAST = SW'(WORD_LENGTH - 1);

  logic [2:0]    state, next_state;
  logic [SW-1:0] shift_cnt;
  logic          timed_out;

  assign op_ready = (state == IDLE);

`ifdef MULT_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] wait_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    wait_cnt <= '0;
    else if (state == FSHIFT)     wait_cnt <= '0;
    else if (state == WAIT_READY) wait_cnt <= wait_cnt + 1'b1;
  end

  // Last allowed WAIT_READY cycle; ready still low here means give up.
  assign timed_out = (wait_cnt == WAIT_LAST);
`else
  // Timeout disabled: constant-false, no counter; parameter kept for a uniform interface.
  assign timed_out = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    next_state = state;
    case (state)
      IDLE:       if (op_valid) next_state = START;
      START:      next_state = LOAD;
      LOAD:       next_state = SHIFT;
      SHIFT:      if (shift_cnt == SHIFT_LAST) next_state = FSHIFT;
      FSHIFT:     next_state = WAIT_READY;
      WAIT_READY: begin
        if (ready)          next_state = FINISH;
        else if (timed_out) next_state = CLEAR;
      end
      FINISH:     next_state = CLEAR;
      CLEAR:      next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == LOAD)       shift_cnt <= '0;
      else if (state == SHIFT) shift_cnt <= shift_cnt + 1'b1;
    end
  end

  // Strobes decode next_state so they line up exactly with the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Start        <= 1'b0;
      FinishLoad   <= 1'b0;
      FinishShift  <= 1'b0;
      Finish       <= 1'b0;
      Reset_Sync   <= 1'b0;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      Start        <= (next_state == START);
      FinishLoad   <= (next_state == LOAD);
      FinishShift  <= (next_state == FSHIFT);
      Finish       <= (next_state == FINISH);
      Reset_Sync   <= (next_state == CLEAR);
      result_valid <= (state == FINISH);
      timeout_err  <= (state == WAIT_READY) && (next_state == CLEAR);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_in_a   <= '0;
      data_in_b   <= '0;
      result      <= '0;
      result_cout <= 1'b0;
    end else begin
      if (state == IDLE && op_valid) begin
        data_in_a <= op_a;
        data_in_b <= op_b;
      end
      if (state == FINISH) begin
        result      <= data_out;
        result_cout <= cout;
      end
    end
  end

endmodule
